// File: rtl/demo_pkg.sv
// Shared definitions for the demo board front-panel controller.
//   - mstate_e : per-master request state (IDLE / REQ)
//   - SEG_BLANK: active-low segment pattern for a dark digit
//   - data_w() : operand width derived from the number of hex digits
//   - hex7seg(): nibble to active-low 7-segment pattern, bit order gfedcba
package demo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } mstate_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // One nibble per digit, so the operand is exactly as wide as the display.
   function automatic int data_w(input int num_hex);
      return 4 * num_hex;
   endfunction

   function automatic logic [6:0] hex7seg(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push key.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   key_n_i : raw key, active-low, asynchronous to clk
//   press_o : one-cycle pulse when the debounced level goes released -> pressed
// The raw key is brought in through a two-flop synchroniser. The debounced
// level only follows the synchronised key after it has differed for
// DEB_CYCLES consecutive cycles; any return to the debounced level restarts
// the count, so shorter glitches are swallowed.
module key_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n_i,
   output logic press_o
);

   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The press pulse is raised in the cycle the new level is committed, so
   // downstream logic sees it on the same edge that stable_q flips.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_o  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            press_o  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_n_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/demo_ctrl.sv
// Front-panel controller for system-bus demo boards.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   keysn     : raw active-low keys (key i < NUM_MASTERS launches master i,
//               key NUM_MASTERS toggles the display mode, others unused)
//   sws       : raw slide switches; low DATA_W bits are the operand
//   m_ready   : master i accepts its pending start this cycle
//   m_start   : level start request to master i, held until accepted
//   m_data    : operand for master i, slice [i*DATA_W +: DATA_W]
//   m_drop    : sticky flag, a press on key i arrived while request i pending
//   disp_mode : 0 = display live switches, 1 = display last launched operand
//   hex       : active-low 7-segment digits, digit d = [d*7 +: 7], gfedcba
module demo_ctrl
   import demo_pkg::*;
#(
   parameter int NUM_KEYS    = 4,
   parameter int NUM_MASTERS = 2,
   parameter int SW_W        = 18,
   parameter int NUM_HEX     = 4,
   parameter int DEB_CYCLES  = 16,
   localparam int DATA_W     = data_w(NUM_HEX)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_KEYS-1:0]           keysn,
   input  logic [SW_W-1:0]               sws,
   input  logic [NUM_MASTERS-1:0]        m_ready,
   output logic [NUM_MASTERS-1:0]        m_start,
   output logic [NUM_MASTERS*DATA_W-1:0] m_data,
   output logic [NUM_MASTERS-1:0]        m_drop,
   output logic                          disp_mode,
   output logic [NUM_HEX*7-1:0]          hex
);

   logic [NUM_KEYS-1:0]                     key_press;
   logic [DATA_W-1:0]                       sw_s1_q;
   logic [DATA_W-1:0]                       sw_s2_q;
   mstate_e                                 state_q [NUM_MASTERS];
   mstate_e                                 state_d [NUM_MASTERS];
   logic [NUM_MASTERS-1:0][DATA_W-1:0]      data_q;
   logic [NUM_MASTERS-1:0][DATA_W-1:0]      data_d;
   logic [NUM_MASTERS-1:0]                  drop_q;
   logic [NUM_MASTERS-1:0]                  drop_d;
   logic [NUM_MASTERS-1:0]                  xfer;
   logic [DATA_W-1:0]                       last_q;
   logic [DATA_W-1:0]                       last_d;
   logic                                    mode_q;
   logic                                    mode_d;
   logic [DATA_W-1:0]                       disp_src;
   logic [NUM_HEX*7-1:0]                    hex_q;
   logic [NUM_HEX*7-1:0]                    hex_d;
   logic                                    unused_inputs;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .key_n_i (keysn[k]),
         .press_o (key_press[k])
      );
   end

   // Spare keys and switches above the operand width are intentionally idle.
   assign unused_inputs = ^{key_press, sws};

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         state_d[i] = state_q[i];
         data_d[i]  = data_q[i];
         drop_d[i]  = drop_q[i];
         xfer[i]    = 1'b0;
         case (state_q[i])
            IDLE: begin
               if (key_press[i]) begin
                  state_d[i] = REQ;
                  data_d[i]  = sw_s2_q;
               end
            end
            REQ: begin
               // A repeat press is only flagged; the pending operand is kept.
               if (key_press[i]) begin
                  drop_d[i] = 1'b1;
               end
               if (m_ready[i]) begin
                  state_d[i] = IDLE;
                  xfer[i]    = 1'b1;
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end

      // Walk from the top down so the lowest transferring index wins.
      last_d = last_q;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (xfer[i]) begin
            last_d = data_q[i];
         end
      end

      mode_d   = mode_q ^ key_press[NUM_MASTERS];
      disp_src = mode_q ? last_q : sw_s2_q;
      hex_d    = '0;
      for (int d = 0; d < NUM_HEX; d++) begin
         hex_d[d*7 +: 7] = hex7seg(disp_src[d*4 +: 4]);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_start[i] = (state_q[i] == REQ);
      end
   end

   assign m_data    = data_q;
   assign m_drop    = drop_q;
   assign disp_mode = mode_q;
   assign hex       = hex_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            state_q[i] <= IDLE;
         end
         data_q <= '0;
         drop_q <= '0;
         last_q <= '0;
         mode_q <= 1'b0;
         hex_q  <= {NUM_HEX{SEG_BLANK}};
      end else begin
         sw_s1_q <= sws[DATA_W-1:0];
         sw_s2_q <= sw_s1_q;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            state_q[i] <= state_d[i];
         end
         data_q <= data_d;
         drop_q <= drop_d;
         last_q <= last_d;
         mode_q <= mode_d;
         hex_q  <= hex_d;
      end
   end

endmodule

// File: tb/tb_demo_ctrl.sv
// Self-checking bench for demo_ctrl with DEB_CYCLES = 4.
module tb_demo_ctrl;

   localparam int NK  = 4;
   localparam int NM  = 2;
   localparam int SWW = 18;
   localparam int NH  = 4;
   localparam int DEB = 4;
   localparam int DW  = 4 * NH;

   logic              clk = 1'b0;
   logic              rst;
   logic [NK-1:0]     keysn;
   logic [SWW-1:0]    sws;
   logic [NM-1:0]     m_ready;
   logic [NM-1:0]     m_start;
   logic [NM*DW-1:0]  m_data;
   logic [NM-1:0]     m_drop;
   logic              disp_mode;
   logic [NH*7-1:0]   hex;

   int n_checks = 0;
   int n_fail   = 0;

   demo_ctrl #(
      .NUM_KEYS    (NK),
      .NUM_MASTERS (NM),
      .SW_W        (SWW),
      .NUM_HEX     (NH),
      .DEB_CYCLES  (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .keysn     (keysn),
      .sws       (sws),
      .m_ready   (m_ready),
      .m_start   (m_start),
      .m_data    (m_data),
      .m_drop    (m_drop),
      .disp_mode (disp_mode),
      .hex       (hex)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Standard active-low 7-segment glyphs, gfedcba.
   function automatic logic [6:0] seg(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   function automatic logic [27:0] show(input logic [15:0] v);
      return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
   endfunction

   // Reference model: inputs reach the controller two cycles late; a key
   // level is believed once it has disagreed with the believed level for DEB
   // consecutive samples; a believed press launches, flags or toggles.
   logic [NK-1:0] mk1, mk2, mbel;
   int            mrun [NK];
   logic [DW-1:0] ms1, ms2;
   logic [NM-1:0] mpend, mdrop;
   logic [DW-1:0] mdat [NM];
   logic [DW-1:0] mlast;
   logic          mmode;
   logic [27:0]   mhex;
   bit            mvalid = 1'b0;

   always @(posedge clk) begin : model
      logic [NK-1:0] pr;
      bit            taken;
      if (rst) begin
         mk1 = '1; mk2 = '1; mbel = '1;
         for (int k = 0; k < NK; k++) mrun[k] = 0;
         ms1 = '0; ms2 = '0;
         mpend = '0; mdrop = '0;
         for (int i = 0; i < NM; i++) mdat[i] = '0;
         mlast = '0; mmode = 1'b0; mhex = 28'hFFFFFFF;
         mvalid = 1'b1;
      end else if (mvalid) begin
         pr = '0;
         for (int k = 0; k < NK; k++) begin
            if (mk2[k] != mbel[k]) begin
               mrun[k] = mrun[k] + 1;
               if (mrun[k] == DEB) begin
                  mbel[k] = mk2[k];
                  mrun[k] = 0;
                  pr[k]   = ~mk2[k];
               end
            end else begin
               mrun[k] = 0;
            end
         end
         mhex  = show(mmode ? mlast : ms2);
         taken = 1'b0;
         for (int i = 0; i < NM; i++) begin
            if (mpend[i]) begin
               if (pr[i]) mdrop[i] = 1'b1;
               if (m_ready[i]) begin
                  mpend[i] = 1'b0;
                  if (!taken) begin
                     mlast = mdat[i];
                     taken = 1'b1;
                  end
               end
            end else if (pr[i]) begin
               mpend[i] = 1'b1;
               mdat[i]  = ms2;
            end
         end
         if (pr[NM]) mmode = ~mmode;
         mk2 = mk1; mk1 = keysn;
         ms2 = ms1; ms1 = sws[DW-1:0];
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("m_start",   64'(m_start),   64'(mpend));
         check("m_data",    64'(m_data),    64'({mdat[1], mdat[0]}));
         check("m_drop",    64'(m_drop),    64'(mdrop));
         check("disp_mode", 64'(disp_mode), 64'(mmode));
         check("hex",       64'(hex),       64'(mhex));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int k);
      keysn[k] = 1'b0;
      tick(DEB + 3);
      keysn[k] = 1'b1;
      tick(DEB + 3);
   endtask

   initial begin
      int lat;
      int hold [NK];
      rst = 1'b1; keysn = '1; sws = '0; m_ready = '0;

      // Reset
      tick(2);
      check("rst_hex",   64'(hex),       64'(28'hFFFFFFF));
      check("rst_start", 64'(m_start),   64'(0));
      check("rst_drop",  64'(m_drop),    64'(0));
      check("rst_mode",  64'(disp_mode), 64'(0));
      sws = 18'h0ABCD;
      rst = 1'b0;
      tick(4);
      check("live_hex", 64'(hex), 64'({7'h08, 7'h03, 7'h46, 7'h21}));

      // Bounce
      keysn[0] = 1'b0; tick(3); keysn[0] = 1'b1; tick(10);
      check("glitch_start", 64'(m_start), 64'(0));
      lat = 0;
      keysn[0] = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (m_start[0] && lat == 0) lat = j;
      end
      keysn[0] = 1'b1;
      tick(DEB + 3);
      check("press_latency", 64'(lat), 64'(6));
      m_ready[0] = 1'b1; tick(); m_ready[0] = 1'b0;

      // Handshake
      sws = 18'h0A5C3; tick(3);
      press(0);
      check("hs_start", 64'(m_start[0]), 64'(1));
      check("hs_data",  64'(m_data[15:0]), 64'(16'hA5C3));
      sws = 18'h3FFFF;
      for (int j = 0; j < 5; j++) begin
         tick();
         check("hs_hold", 64'({m_start[0], m_data[15:0]}), 64'({1'b1, 16'hA5C3}));
      end
      m_ready[0] = 1'b1; tick(); m_ready[0] = 1'b0;
      check("hs_accept", 64'(m_start[0]), 64'(0));

      // Drop and concurrency
      sws = 18'h05555; tick(3);
      keysn[1:0] = 2'b00; tick(DEB + 3); keysn[1:0] = 2'b11; tick(DEB + 3);
      check("both_start", 64'(m_start), 64'(2'b11));
      sws = 18'h00777; tick(3);
      press(0);
      check("drop", 64'(m_drop), 64'(2'b01));
      check("drop_data", 64'(m_data), 64'({16'h5555, 16'h5555}));
      rst = 1'b1; tick(); rst = 1'b0;
      check("drop_clr", 64'(m_drop), 64'(0));

      // Display mode
      sws = 18'h01234; tick(3);
      press(1);
      m_ready[1] = 1'b1; tick(); m_ready[1] = 1'b0;
      sws = 18'h0BEEF; tick(3);
      press(2);
      check("mode_on", 64'(disp_mode), 64'(1));
      check("mode_hex", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
      check("mode_dig0", 64'(hex[6:0]), 64'(7'h19));
      press(2);
      check("mode_off", 64'(disp_mode), 64'(0));
      check("live_beef", 64'(hex), 64'({7'h03, 7'h06, 7'h06, 7'h0E}));

      // Reset mid-request
      press(1);
      check("req1", 64'(m_start[1]), 64'(1));
      rst = 1'b1; tick();
      check("midrst_start", 64'(m_start), 64'(0));
      check("midrst_hex", 64'(hex), 64'(28'hFFFFFFF));
      rst = 1'b0; tick();
      m_ready[1] = 1'b1; tick(); m_ready[1] = 1'b0; tick(3);
      press(2);
      check("last_zero", 64'(hex), 64'({4{7'h40}}));
      press(2);

      // Randomised traffic
      for (int k = 0; k < NK; k++) hold[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (hold[k] == 0) begin
               keysn[k] = 1'($urandom_range(0, 1));
               hold[k]  = int'($urandom_range(1, 9));
            end else begin
               hold[k] = hold[k] - 1;
            end
         end
         m_ready = NM'($urandom);
         if ($urandom_range(0, 15) == 0) sws = SWW'($urandom);
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; keysn = '1; m_ready = '0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demo_ctrl.md
Name: demo_ctrl

Overview:
Parametrised front-panel controller for system-bus demo boards: debounces active-low push keys, turns presses into per-master start requests with a ready handshake, and drives 7-segment hex digits.
Generalises the fixed 4-key/2-master/4-digit demo top. Adds debounce, a start/ready handshake with captured operand, a dropped-press flag and a selectable display source.
Sits between board I/O (KEY/SW/HEX) and the bus masters' start/operand inputs.

Parameters:
NUM_KEYS, 4, number of active-low keys; must be >= NUM_MASTERS+1
NUM_MASTERS, 2, number of bus masters launched from keys
SW_W, 18, switch width; must be >= 4*NUM_HEX
NUM_HEX, 4, number of 7-segment digits; DATA_W = 4*NUM_HEX
DEB_CYCLES, 16, consecutive stable cycles required to accept a key change (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
keysn  in  NUM_KEYS  raw keys, active-low, asynchronous to clk
sws  in  SW_W  raw slide switches, asynchronous to clk
m_ready  in  NUM_MASTERS  master i accepts a start this cycle
m_start  out  NUM_MASTERS  start request to master i, level, held until accepted
m_data  out  NUM_MASTERS*DATA_W  operand for master i; slice i = bits [i*DATA_W +: DATA_W]
m_drop  out  NUM_MASTERS  sticky: a press on key i arrived while request i was pending
disp_mode  out  1  0 = live switches, 1 = last launched operand
hex  out  NUM_HEX*7  7-seg segments, active-low; digit d = bits [d*7 +: 7], seg order gfedcba

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, sampled on posedge clk. All state is reset by rst.
- Reset values:
  - m_start=0, m_data=0, m_drop=0, disp_mode=0.
  - hex = all 7'h7F (blank).
  - Debounced key state = 1 (released); debounce counters = 0; last-launched register = 0.
- Input sync: keysn and sws pass through 2-flop synchronisers; synchronisers reset to keysn=1s, sws=0.
- Debounce, per key:
  - Counter increments while synced raw != stable, and clears when they are equal.
  - On reaching DEB_CYCLES-1, stable takes the raw value and the counter clears.
  - A press event is a one-cycle pulse on a stable 1->0 transition. Releases generate no event.
  - Latency from keysn edge to press pulse = 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES cycles produce no event.
- Per-master FSM (i < NUM_MASTERS), states IDLE and REQ:
  - IDLE + press[i] -> REQ. m_start[i]=1 and m_data slice i = synced sws[DATA_W-1:0] from the next edge on.
  - REQ + m_ready[i]=1 -> IDLE (transfer). m_start[i]=0 next cycle. The last-launched register takes the slice-i value.
  - If several masters transfer in the same cycle, the lowest index wins the last-launched register.
  - REQ + press[i] -> m_drop[i] set; request and m_data are unchanged.
  - m_drop[i] clears only on rst.
  - m_data is stable for the whole of REQ. m_ready while IDLE is ignored.
  - Masters are independent: simultaneous presses produce simultaneous requests.
- Mode key (index NUM_MASTERS): each press toggles disp_mode. Keys above NUM_MASTERS are debounced but unused.
- Display:
  - Source = disp_mode ? last-launched : synced sws[DATA_W-1:0].
  - Digit d shows nibble d, hex-encoded 0-F in active-low.
  - hex is registered: one cycle after a source or mode change.
- Reset mid-operation: rst during REQ forces IDLE, m_start=0 and hex blank at that edge. The first valid digits appear one cycle after rst deasserts.

Decomposition:
- Package demo_pkg holds:
  - the hex-to-7-seg encode function/constant table (0-F, active-low, blank = 7'h7F);
  - the FSM state enum {IDLE, REQ};
  - the DATA_W derivation.
- Sub-module key_debounce (one instance per key, parameter DEB_CYCLES): synchroniser, counter, stable level, press pulse. Instantiated in a generate loop.

Test Plan:
All scenarios use DEB_CYCLES=4.
1. Reset: assert rst 2 cycles with keys released -> m_start=0, m_drop=0, disp_mode=0, hex=28'hFFFFFFF. One cycle after release, hex shows live sws.
2. Bounce: keysn[0] low for 3 cycles then high -> no m_start. Held low 10 cycles -> m_start[0]=1 exactly 6 cycles after the fall.
3. Handshake: sws=18'h0A5C3, press key0, m_ready[0]=0 for 5 cycles then 1 -> m_start[0] high throughout, m_data[15:0]=16'hA5C3. m_start[0]=0 the cycle after the accept.
4. Drop + concurrency: press key0 and key1 in the same cycle, m_ready=0 -> both m_start high. Press key0 again -> m_drop[0]=1, m_drop[1]=0, m_data unchanged. rst -> m_drop=0.
5. Display mode: launch 16'h1234 via master1, sws=16'hBEEF, press key2 -> disp_mode=1 and hex shows 1,2,3,4 (digit0=4 -> 7'h19). Press key2 again -> hex shows live F,E,E,B.
6. Reset mid-REQ: rst while m_start[1]=1 -> m_start[1]=0 at that edge. A later m_ready[1] pulse does not update last-launched.
